h3_hash_bucket_ctrl: RTL and testbench
======================================

Name: h3_hash_bucket_ctrl

Overview:
- Downstream consumer of the H3 hash stage.
- Accepts a key plus its already-computed bucket address and performs LOOKUP, INSERT or DELETE on a single-entry-per-bucket register table.
- Returns status and value over a valid/ready response channel.
- Forms the storage/control half of the hash table pipeline; the hash function stays purely combinational upstream.

Parameters:
- KEY_WIDTH, 32: key width in bits; must match the upstream hash key_in.
- HASH_ADR_WIDTH, 8: bucket address width; table depth = 2**HASH_ADR_WIDTH.
- VALUE_WIDTH, 32: stored value width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=reserved.
- req_key  in  KEY_WIDTH  key.
- req_hash_adr  in  HASH_ADR_WIDTH  bucket address from the hash stage.
- req_value  in  VALUE_WIDTH  value for INSERT; ignored otherwise.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_status  out  2  0=OK, 1=MISS, 2=COLLISION, 3=ILLEGAL.
- rsp_value  out  VALUE_WIDTH  result value.

Behaviour:
- Table: per bucket {valid, key, value}.
- Reset (async assert, sync-free deassert):
  - All valid bits = 0; FSM = IDLE.
  - req_ready=0 while rst_n low, 1 in the first IDLE cycle after release.
  - rsp_valid=0, rsp_status=0, rsp_value=0.
- FSM IDLE -> READ -> EXEC -> RESP -> IDLE.
  - IDLE: req_ready=1. On req_valid&&req_ready at a clock edge, latch op/key/adr/value and go to READ. Inputs are don't-care afterwards.
  - READ: register the bucket entry at the latched address.
  - EXEC: compare and compute status/value; perform the table write at the end of this cycle.
  - RESP: rsp_valid=1; status and value held stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE; rsp_valid=0 next cycle.
- Latency: rsp_valid rises 3 cycles after the accept edge. Throughput 1 request per 4 cycles with rsp_ready held high. req_ready=0 in READ/EXEC/RESP.
- LOOKUP:
  - Bucket valid and key equal -> OK, rsp_value = stored value.
  - Otherwise -> MISS, rsp_value = 0.
- INSERT:
  - Bucket empty -> write, OK, rsp_value = req_value.
  - Bucket valid and key equal -> overwrite value, OK, rsp_value = new value.
  - Bucket valid and key different -> no write, COLLISION, rsp_value = 0.
- DELETE:
  - Bucket valid and key equal -> clear valid, OK, rsp_value = old value.
  - Otherwise -> MISS, rsp_value = 0, no write.
- op=3: ILLEGAL, rsp_value = 0, no table access side effects.
- Back-pressure: RESP holds indefinitely while rsp_ready=0. No new request is accepted meanwhile.
- Reset mid-operation: in-flight request discarded, no response, no partial write. A write in EXEC either completes before reset assertion or does not occur.
- Table write happens only in EXEC, so request N+1 always sees the result of request N.

Optional Feature:
- Macro HASH_BUCKET_OCCUPANCY_EN.
- Defined:
  - Adds output port occupancy, width HASH_ADR_WIDTH+1, reset 0.
  - +1 on INSERT into an empty bucket; -1 on successful DELETE.
  - Updates in the same edge as the table write.
  - Never exceeds 2**HASH_ADR_WIDTH, never underflows.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
(KEY_WIDTH=4, HASH_ADR_WIDTH=2, VALUE_WIDTH=8, rsp_ready=1 unless stated)
- Reset, then LOOKUP key=4'h5 adr=1 -> rsp_valid exactly 3 cycles after accept, status MISS, value 0, req_ready low for 3 cycles after accept.
- INSERT key=5 adr=1 value=8'hA5, then LOOKUP key=5 adr=1 -> OK/A5 then OK/A5. Occupancy 1 if enabled.
- INSERT key=9 adr=1 value=8'h3C after the above -> COLLISION, value 0. Following LOOKUP key=5 -> still A5.
- INSERT key=5 adr=1 value=8'h11 (overwrite) -> OK/11, occupancy unchanged. DELETE key=5 -> OK/11, occupancy 0. LOOKUP key=5 -> MISS.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid/status/value stable. req_valid asserted meanwhile not accepted. Release -> IDLE next cycle, then pending request accepted.
- Fill adr 0..3, then assert rst_n=0 during EXEC of a DELETE -> outputs 0 immediately. After release all LOOKUPs -> MISS, occupancy 0. op=3 request -> ILLEGAL.

Source files
------------

// File: rtl/h3_hash_bucket_ctrl.sv
// Single-entry-per-bucket hash table controller: LOOKUP/INSERT/DELETE behind a 4-state FSM.
// Optional macro HASH_BUCKET_OCCUPANCY_EN adds a live count of occupied buckets.
module h3_hash_bucket_ctrl #(
  parameter int KEY_WIDTH      = 32,
  parameter int HASH_ADR_WIDTH = 8,
  parameter int VALUE_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [KEY_WIDTH-1:0]      req_key,
  input  logic [HASH_ADR_WIDTH-1:0] req_hash_adr,
  input  logic [VALUE_WIDTH-1:0]    req_value,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [1:0]                rsp_status,
`ifdef HASH_BUCKET_OCCUPANCY_EN
  output logic [HASH_ADR_WIDTH:0]   occupancy,
`endif
  output logic [VALUE_WIDTH-1:0]    rsp_value
);

  localparam int DEPTH = 1 << HASH_ADR_WIDTH;
  localparam logic [1:0] OP_LOOKUP = 2'd0, OP_INSERT = 2'd1, OP_DELETE = 2'd2;
  localparam logic [1:0] ST_OK = 2'd0, ST_MISS = 2'd1, ST_COLL = 2'd2, ST_ILL = 2'd3;

  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                op_q, op_d;
  logic [KEY_WIDTH-1:0]      key_q, key_d;
  logic [HASH_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [VALUE_WIDTH-1:0]    val_q, val_d;
  logic                      ent_vld_q, ent_vld_d;
  logic [KEY_WIDTH-1:0]      ent_key_q, ent_key_d;
  logic [VALUE_WIDTH-1:0]    ent_val_q, ent_val_d;
  logic [1:0]                rsp_status_q, rsp_status_d;
  logic [VALUE_WIDTH-1:0]    rsp_value_q, rsp_value_d;

  logic [DEPTH-1:0]          tbl_vld_q;
  logic [KEY_WIDTH-1:0]      tbl_key_q [DEPTH];
  logic [VALUE_WIDTH-1:0]    tbl_val_q [DEPTH];

  logic                      we, w_vld, hit;
  logic [VALUE_WIDTH-1:0]    w_val;

  // Gate with rst_n so the block never advertises readiness while held in reset.
  assign req_ready  = rst_n && (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_status = rsp_status_q;
  assign rsp_value  = rsp_value_q;
  assign hit        = ent_vld_q && (ent_key_q == key_q);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    key_d        = key_q;
    adr_d        = adr_q;
    val_d        = val_q;
    ent_vld_d    = ent_vld_q;
    ent_key_d    = ent_key_q;
    ent_val_d    = ent_val_q;
    rsp_status_d = rsp_status_q;
    rsp_value_d  = rsp_value_q;
    we           = 1'b0;
    w_vld        = 1'b0;
    w_val        = val_q;
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        op_d    = req_op;
        key_d   = req_key;
        adr_d   = req_hash_adr;
        val_d   = req_value;
        state_d = READ;
      end
      READ: begin
        ent_vld_d = tbl_vld_q[adr_q];
        ent_key_d = tbl_key_q[adr_q];
        ent_val_d = tbl_val_q[adr_q];
        state_d   = EXEC;
      end
      EXEC: begin
        state_d     = RESP;
        rsp_value_d = '0;
        case (op_q)
          OP_LOOKUP: if (hit) begin
            rsp_status_d = ST_OK;
            rsp_value_d  = ent_val_q;
          end else rsp_status_d = ST_MISS;
          OP_INSERT: if (!ent_vld_q || hit) begin
            we           = 1'b1;
            w_vld        = 1'b1;
            rsp_status_d = ST_OK;
            rsp_value_d  = val_q;
          end else rsp_status_d = ST_COLL;
          OP_DELETE: if (hit) begin
            we           = 1'b1;
            w_val        = ent_val_q;
            rsp_status_d = ST_OK;
            rsp_value_d  = ent_val_q;
          end else rsp_status_d = ST_MISS;
          default: rsp_status_d = ST_ILL;
        endcase
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      key_q        <= '0;
      adr_q        <= '0;
      val_q        <= '0;
      ent_vld_q    <= 1'b0;
      ent_key_q    <= '0;
      ent_val_q    <= '0;
      rsp_status_q <= '0;
      rsp_value_q  <= '0;
      tbl_vld_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      key_q        <= key_d;
      adr_q        <= adr_d;
      val_q        <= val_d;
      ent_vld_q    <= ent_vld_d;
      ent_key_q    <= ent_key_d;
      ent_val_q    <= ent_val_d;
      rsp_status_q <= rsp_status_d;
      rsp_value_q  <= rsp_value_d;
      if (we) tbl_vld_q[adr_q] <= w_vld;
    end
  end

  // Key/value storage needs no reset: the valid bit alone qualifies an entry.
  always_ff @(posedge clk) begin
    if (we) begin
      tbl_key_q[adr_q] <= key_q;
      tbl_val_q[adr_q] <= w_val;
    end
  end

`ifdef HASH_BUCKET_OCCUPANCY_EN
  logic [HASH_ADR_WIDTH:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (we && w_vld && !ent_vld_q) occ_d = occ_q + 1'b1;
    else if (we && !w_vld)         occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_h3_hash_bucket_ctrl.sv
// Randomized + directed bench for h3_hash_bucket_ctrl against an array-based table model.
module tb_h3_hash_bucket_ctrl;
  localparam int KW = 4, AW = 2, VW = 8, D = 4;

  logic          clk, rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]    req_op, rsp_status;
  logic [KW-1:0] req_key;
  logic [AW-1:0] req_hash_adr;
  logic [VW-1:0] req_value, rsp_value;
`ifdef HASH_BUCKET_OCCUPANCY_EN
  logic [AW:0]   occupancy;
`endif

  h3_hash_bucket_ctrl #(.KEY_WIDTH(KW), .HASH_ADR_WIDTH(AW), .VALUE_WIDTH(VW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .req_hash_adr(req_hash_adr), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
`ifdef HASH_BUCKET_OCCUPANCY_EN
    .occupancy(occupancy),
`endif
    .rsp_value(rsp_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0, errs = 0;

  // Reference table: plain arrays indexed by bucket
  logic          m_vld [D];
  logic [KW-1:0] m_key [D];
  logic [VW-1:0] m_val [D];
  int            m_occ;

  typedef struct packed { logic [1:0] st; logic [VW-1:0] v; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) m_vld[i] = 1'b0;
    m_occ = 0;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [KW-1:0] k,
                             input logic [AW-1:0] a, input logic [VW-1:0] v);
    exp_t e;
    logic hit;
    hit = m_vld[a] && (m_key[a] == k);
    e.st = 2'd1; e.v = '0;
    case (op)
      2'd0: if (hit) begin e.st = 2'd0; e.v = m_val[a]; end
      2'd1: begin
        if (!m_vld[a]) begin
          m_vld[a] = 1'b1; m_key[a] = k; m_val[a] = v; m_occ++;
          e.st = 2'd0; e.v = v;
        end else if (hit) begin
          m_val[a] = v; e.st = 2'd0; e.v = v;
        end else e.st = 2'd2;
      end
      2'd2: if (hit) begin
        m_vld[a] = 1'b0; m_occ--; e.st = 2'd0; e.v = m_val[a];
      end
      default: e.st = 2'd3;
    endcase
    exp_q.push_back(e);
  endtask

  // Compare process: every response cycle is checked against the model's head entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
      else begin
        chk("rsp_status", 32'(rsp_status), 32'(exp_q[0].st));
        chk("rsp_value", 32'(rsp_value), 32'(exp_q[0].v));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && rsp_valid && rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  // Entered and left at a negedge with the DUT idle.
  task automatic run_req(input logic [1:0] op, input logic [KW-1:0] k, input logic [AW-1:0] a,
                         input logic [VW-1:0] v, input int stall, input bit hold_next,
                         input logic [1:0] nop, input logic [KW-1:0] nk, input logic [AW-1:0] na,
                         input logic [VW-1:0] nv, output logic [1:0] gs, output logic [VW-1:0] gv);
    int g;
    gs = '0; gv = '0;
    req_valid = 1'b1; req_op = op; req_key = k; req_hash_adr = a; req_value = v;
    rsp_ready = (stall == 0);
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    model_apply(op, k, a, v);
    @(negedge clk);
    if (hold_next) begin
      req_op = nop; req_key = nk; req_hash_adr = na; req_value = nv;
    end else begin
      req_valid = 1'b0; req_key = KW'($urandom); req_value = VW'($urandom);
      req_op = 2'($urandom); req_hash_adr = AW'($urandom);
    end
    for (int n = 1; n <= 3; n++) begin
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("rsp_valid_latency", 32'(rsp_valid), 32'(n == 3));
      if (n < 3) @(negedge clk);
    end
    gs = rsp_status; gv = rsp_value;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_no_accept", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
`ifdef HASH_BUCKET_OCCUPANCY_EN
    chk("occupancy", 32'(occupancy), 32'(m_occ));
`endif
  endtask

  task automatic req(input logic [1:0] op, input logic [KW-1:0] k, input logic [AW-1:0] a,
                     input logic [VW-1:0] v, output logic [1:0] gs, output logic [VW-1:0] gv);
    run_req(op, k, a, v, 0, 1'b0, 2'd0, '0, '0, '0, gs, gv);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]    gs;
    logic [VW-1:0] gv;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_key = '0; req_hash_adr = '0;
    req_value = '0; rsp_ready = 1'b1;
    model_clear();
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_rsp_value", 32'(rsp_value), 32'd0);
    @(negedge clk);
    do_reset();

    // Hand-computed expectations pin the model as well as the DUT.
    req(2'd0, 4'h5, 2'd1, 8'h00, gs, gv);
    chk("t1_lookup_miss", {22'd0, gs, gv}, {22'd0, 2'd1, 8'h00});
    req(2'd1, 4'h5, 2'd1, 8'hA5, gs, gv);
    chk("t2_insert", {22'd0, gs, gv}, {22'd0, 2'd0, 8'hA5});
    req(2'd0, 4'h5, 2'd1, 8'h00, gs, gv);
    chk("t2_lookup", {22'd0, gs, gv}, {22'd0, 2'd0, 8'hA5});
    req(2'd1, 4'h9, 2'd1, 8'h3C, gs, gv);
    chk("t3_collision", {22'd0, gs, gv}, {22'd0, 2'd2, 8'h00});
    req(2'd0, 4'h5, 2'd1, 8'h00, gs, gv);
    chk("t3_lookup_kept", {22'd0, gs, gv}, {22'd0, 2'd0, 8'hA5});
    req(2'd1, 4'h5, 2'd1, 8'h11, gs, gv);
    chk("t4_overwrite", {22'd0, gs, gv}, {22'd0, 2'd0, 8'h11});
    req(2'd2, 4'h5, 2'd1, 8'h00, gs, gv);
    chk("t4_delete", {22'd0, gs, gv}, {22'd0, 2'd0, 8'h11});
    req(2'd0, 4'h5, 2'd1, 8'h00, gs, gv);
    chk("t4_lookup_gone", {22'd0, gs, gv}, {22'd0, 2'd1, 8'h00});

    // Back-pressure with a pending request held on the input.
    run_req(2'd1, 4'h7, 2'd2, 8'h42, 5, 1'b1, 2'd0, 4'h7, 2'd2, 8'h00, gs, gv);
    chk("t5_bp_insert", {22'd0, gs, gv}, {22'd0, 2'd0, 8'h42});
    req(2'd0, 4'h7, 2'd2, 8'h00, gs, gv);
    chk("t5_pending_lookup", {22'd0, gs, gv}, {22'd0, 2'd0, 8'h42});

    for (int i = 0; i < 60; i++) begin
      run_req(2'($urandom_range(0, 3)), KW'($urandom_range(0, 3)), AW'($urandom),
              VW'($urandom), int'($urandom_range(0, 2)), 1'b0, 2'd0, '0, '0, '0, gs, gv);
    end

    // Reset in the middle of a DELETE's EXEC cycle.
    do_reset();
    for (int a = 0; a < D; a++) req(2'd1, KW'(a + 1), AW'(a), VW'(8'h10 + a), gs, gv);
    req_valid = 1'b1; req_op = 2'd2; req_key = 4'h1; req_hash_adr = 2'd0; req_value = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_status", 32'(rsp_status), 32'd0);
    chk("midrst_rsp_value", 32'(rsp_value), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 32'(req_ready), 32'd1);
    for (int a = 0; a < D; a++) begin
      req(2'd0, KW'(a + 1), AW'(a), '0, gs, gv);
      chk("post_rst_miss", {22'd0, gs, gv}, {22'd0, 2'd1, 8'h00});
    end
    req(2'd3, 4'h2, 2'd3, 8'hFF, gs, gv);
    chk("illegal_op", {22'd0, gs, gv}, {22'd0, 2'd3, 8'h00});

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
